branch_pc_sequencer: RTL and testbench

Program-counter sequencer at the consuming end of the branch path. It receives the delayed branch condition mask and branch target from the branch decode stage, and ANDs the mask with the live ALU status flags to resolve each branch. It then redirects the instruction-memory fetch address, and kills the younger instructions already in flight. It sits between the branch decode stage and the instruction memory, and is the only writer of the fetch PC.

---
 rtl/branch_pc_sequencer.sv | 105 ++++++++++
 tb/tb_branch_pc_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/branch_pc_sequencer.sv
// Fetch-PC sequencer: resolves branches against live ALU flags, redirects fetch and
// kills the younger in-flight instructions after a taken branch.
module branch_pc_sequencer #(
    parameter int FLAGS_LENGTH = 8,
    parameter int PC_WIDTH     = 10,
    parameter int PC_START     = 0,
    parameter int FLUSH_DEPTH  = 3
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    ENABLE,
    input  logic                    START,
    input  logic                    HALT_REQ,
    input  logic [FLAGS_LENGTH-1:0] IM_FLAGS,
    input  logic [PC_WIDTH-1:0]     BADDR,
    input  logic [FLAGS_LENGTH-1:0] ALU_STATUS,
    output logic [PC_WIDTH-1:0]     PC,
    output logic                    IM_RD_EN,
    output logic                    FLUSH,
    output logic                    BRANCH_TAKEN,
    output logic                    BUSY,
    output logic                    DONE
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [PC_WIDTH-1:0] START_PC    = PC_WIDTH'(PC_START);
    localparam logic [3:0]          FLUSH_COUNT = 4'(FLUSH_DEPTH);

    state_t     state;
    logic [3:0] flush_cnt;
    logic       taken;

    assign taken = |(IM_FLAGS & ALU_STATUS);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= S_IDLE;
            flush_cnt    <= 4'd0;
            PC           <= START_PC;
            IM_RD_EN     <= 1'b0;
            FLUSH        <= 1'b0;
            BRANCH_TAKEN <= 1'b0;
            BUSY         <= 1'b0;
            DONE         <= 1'b0;
        end else begin
            BRANCH_TAKEN <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        state    <= S_RUN;
                        PC       <= START_PC;
                        IM_RD_EN <= 1'b1;
                        BUSY     <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (ENABLE) begin
                        if (taken) begin
                            state        <= S_FLUSH;
                            PC           <= BADDR;
                            BRANCH_TAKEN <= 1'b1;
                            FLUSH        <= 1'b1;
                            flush_cnt    <= FLUSH_COUNT;
                        end else if (HALT_REQ) begin
                            state    <= S_DONE;
                            IM_RD_EN <= 1'b0;
                            BUSY     <= 1'b0;
                            DONE     <= 1'b1;
                        end else begin
                            PC <= PC + 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    // Flags and halts seen here belong to killed instructions.
                    if (ENABLE) begin
                        PC        <= PC + 1'b1;
                        flush_cnt <= flush_cnt - 1'b1;
                        if (flush_cnt == 4'd1) begin
                            FLUSH <= 1'b0;
                            state <= S_RUN;
                        end
                    end
                end
                S_DONE: begin
                    if (START) begin
                        state    <= S_RUN;
                        PC       <= START_PC;
                        IM_RD_EN <= 1'b1;
                        BUSY     <= 1'b1;
                        DONE     <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// Scoreboard bench: a driver applies directed and random stimulus and queues the
// reference model's expected outputs; a monitor compares them after every edge.
module tb_branch_pc_sequencer;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       ENABLE = 1'b0;
    logic       START = 1'b0;
    logic       HALT_REQ = 1'b0;
    logic [7:0] IM_FLAGS = 8'd0;
    logic [9:0] BADDR = 10'd0;
    logic [7:0] ALU_STATUS = 8'd0;
    logic [9:0] PC;
    logic       IM_RD_EN, FLUSH, BRANCH_TAKEN, BUSY, DONE;

    branch_pc_sequencer dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .START(START), .HALT_REQ(HALT_REQ),
        .IM_FLAGS(IM_FLAGS), .BADDR(BADDR), .ALU_STATUS(ALU_STATUS),
        .PC(PC), .IM_RD_EN(IM_RD_EN), .FLUSH(FLUSH), .BRANCH_TAKEN(BRANCH_TAKEN),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    // Reference model: mode 0 idle, 1 running, 2 killing younger instrs, 3 halted.
    int         m_mode = 0;
    int         m_kill_left = 0;
    logic [9:0] m_pc = 10'd0;
    logic       m_rd = 1'b0;

    typedef struct packed {
        logic [9:0] pc;
        logic       rd;
        logic       flush;
        logic       bt;
        logic       busy;
        logic       done;
    } obs_t;

    obs_t exp_q[$];
    int   compared = 0;
    int   mismatched = 0;
    int   cycle_no = 0;
    bit   driving_done = 1'b0;

    task automatic step(input bit rst, input bit en, input bit st, input bit hr,
                        input logic [7:0] fl, input logic [7:0] st_flags, input logic [9:0] ba);
        obs_t e;
        bit   bt;
        RESET = rst; ENABLE = en; START = st; HALT_REQ = hr;
        IM_FLAGS = fl; ALU_STATUS = st_flags; BADDR = ba;
        bt = 1'b0;
        if (rst) begin
            m_mode = 0; m_pc = 10'd0; m_rd = 1'b0; m_kill_left = 0;
        end else if (m_mode == 0 || m_mode == 3) begin
            if (st) begin
                m_mode = 1; m_pc = 10'd0; m_rd = 1'b1;
            end
        end else if (m_mode == 1) begin
            if (en) begin
                if ((fl & st_flags) != 8'd0) begin
                    m_pc = ba; bt = 1'b1; m_kill_left = 3; m_mode = 2;
                end else if (hr) begin
                    m_mode = 3; m_rd = 1'b0;
                end else begin
                    m_pc = m_pc + 10'd1;
                end
            end
        end else if (en) begin
            m_pc = m_pc + 10'd1;
            m_kill_left = m_kill_left - 1;
            if (m_kill_left == 0) m_mode = 1;
        end
        e.pc = m_pc; e.rd = m_rd; e.flush = (m_mode == 2); e.bt = bt;
        e.busy = (m_mode == 1 || m_mode == 2); e.done = (m_mode == 3);
        exp_q.push_back(e);
        @(negedge CLK);
    endtask

    task automatic idle_steps(input int n, input bit en);
        for (int i = 0; i < n; i++) step(1'b0, en, 1'b0, 1'b0, 8'd0, 8'd0, 10'd0);
    endtask

    task automatic branch(input logic [9:0] ba, input bit hr);
        step(1'b0, 1'b1, 1'b0, hr, 8'b0000_0001, 8'b0000_0001, ba);
    endtask

    // Monitor
    initial begin
        obs_t e, a;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() == 0) begin
                if (!driving_done) begin
                    mismatched++;
                    $display("FAIL scoreboard_empty cycle %0d: no expected entry queued", cycle_no);
                end
            end else begin
                e = exp_q.pop_front();
                a = {PC, IM_RD_EN, FLUSH, BRANCH_TAKEN, BUSY, DONE};
                compared++;
                if (a !== e) begin
                    mismatched++;
                    $display("FAIL outputs cycle %0d: got pc=%0d rd=%b fl=%b bt=%b busy=%b done=%b, want pc=%0d rd=%b fl=%b bt=%b busy=%b done=%b",
                             cycle_no, a.pc, a.rd, a.flush, a.bt, a.busy, a.done,
                             e.pc, e.rd, e.flush, e.bt, e.busy, e.done);
                end
            end
            cycle_no++;
        end
    end

    // Driver
    initial begin
        int guard;
        // Reset and a long sequential run across the 1023 -> 0 wrap
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 10'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 10'd0);
        idle_steps(2, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 10'd0);
        idle_steps(1030, 1'b1);

        // Fresh run, taken branch at PC=20
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 10'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 10'd0);
        guard = 0;
        while (m_pc != 10'd20 && guard < 50) begin
            idle_steps(1, 1'b1);
            guard++;
        end
        branch(10'd300, 1'b0);
        idle_steps(5, 1'b1);

        // Not taken: mask and status disjoint
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'b0000_0001, 8'b0000_0010, 10'd77);

        // Stall during flush; matching flags while flushing must be ignored
        branch(10'd500, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 10'd9);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 10'd9);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF, 10'd9);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 10'd9);
        idle_steps(2, 1'b1);

        // Branch to PC+1 still flushes
        branch(m_pc + 10'd1, 1'b0);
        idle_steps(4, 1'b1);

        // Branch and halt together: branch wins; later halt; restart
        branch(10'd1000, 1'b1);
        idle_steps(4, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 8'd0, 10'd0);
        idle_steps(3, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 10'd0);
        idle_steps(2, 1'b1);

        // Reset mid-flush, then restart with no residual flush
        branch(10'd123, 1'b0);
        idle_steps(1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 10'd0);
        idle_steps(2, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 10'd0);
        idle_steps(5, 1'b1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] f, s;
            f = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'd0;
            s = 8'($urandom);
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 24) == 0),
                 f, s, 10'($urandom));
        end

        driving_done = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            @(negedge CLK);
            guard++;
        end
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
